// File: rtl/pcs_pkg.sv
// Shared types and code-group constants for the 1000BASE-X PCS transmit path.
package pcs_pkg;

  typedef enum logic [1:0] {
    XMIT_IDLE          = 2'd0,
    XMIT_CONFIGURATION = 2'd1,
    XMIT_DATA          = 2'd2
  } xmit_type_t;

  // Four bits wide so that undefined encodings exist and fall back to /I/.
  typedef enum logic [3:0] {
    OS_I  = 4'd0,
    OS_C  = 4'd1,
    OS_S  = 4'd2,
    OS_T  = 4'd3,
    OS_R  = 4'd4,
    OS_V  = 4'd5,
    OS_D  = 4'd6,
    OS_LI = 4'd7
  } ordered_set_t;

  typedef enum logic [3:0] {
    SPECIAL_GO = 4'd0,
    DATA_GO    = 4'd1,
    IDLE_K     = 4'd2,
    IDLE_D     = 4'd3,
    LPI_K      = 4'd4,
    LPI_D      = 4'd5,
    CFG_K      = 4'd6,
    CFG_D      = 4'd7,
    CFG_LO     = 4'd8,
    CFG_HI     = 4'd9
  } tx_cg_state_t;

  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] K27_7 = 8'hFB;
  localparam logic [7:0] K29_7 = 8'hFD;
  localparam logic [7:0] K23_7 = 8'hF7;
  localparam logic [7:0] K30_7 = 8'hFE;
  localparam logic [7:0] D5_6  = 8'hC5;
  localparam logic [7:0] D16_2 = 8'h50;
  localparam logic [7:0] D6_5  = 8'hA6;
  localparam logic [7:0] D26_4 = 8'h9A;
  localparam logic [7:0] D21_5 = 8'hB5;
  localparam logic [7:0] D2_2  = 8'h42;

endpackage

// File: rtl/pcs_xmit_change_detect.sv
// Registers xmit and raises xmit_change until the ordered-set machine reaches an odd set boundary.
module pcs_xmit_change_detect
  import pcs_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       restart,
  input  xmit_type_t xmit,
  input  logic       tx_oset_indicate,
  input  logic       tx_even,
  output logic       xmit_change
);

  xmit_type_t xmit_q;
  logic       change_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xmit_q     <= XMIT_IDLE;
      change_reg <= 1'b0;
    end else if (restart) begin
      xmit_q     <= xmit;
      change_reg <= 1'b0;
    end else begin
      xmit_q <= xmit;
      // A fresh change outranks the acknowledge in the same cycle.
      if (xmit != xmit_q)
        change_reg <= 1'b1;
      else if (tx_oset_indicate && !tx_even)
        change_reg <= 1'b0;
    end
  end

  assign xmit_change = change_reg;

endmodule

// File: rtl/pcs_tx_code_group_seq.sv
// Expands ordered sets into one code-group per clock and paces the ordered-set machine.
module pcs_tx_code_group_seq
  import pcs_pkg::*;
#(
  parameter int CFG_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             power_on,
  input  logic             mr_main_reset,
  input  xmit_type_t       xmit,
  input  ordered_set_t     tx_o_set,
  input  logic [7:0]       TXD,
  input  logic [CFG_W-1:0] tx_config_reg,
  input  logic             tx_disparity_pos,
  output logic [7:0]       tx_cg_data,
  output logic             tx_cg_is_k,
  output logic             tx_even,
  output logic             tx_oset_indicate,
  output logic             xmitCHANGE,
  output logic             align_err,
  output tx_cg_state_t     cg_state
);

  logic restart;
  assign restart = power_on | mr_main_reset;

  tx_cg_state_t     state_reg, state_next;
  logic [7:0]       data_reg, data_next;
  logic             is_k_reg, is_k_next;
  logic             even_reg, even_next;
  logic             ind_reg, ind_next;
  logic             align_reg, align_next;
  logic             c_toggle_reg, c_toggle_next;
  logic [CFG_W-1:0] cfg_reg, cfg_next;
  logic             sample;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= SPECIAL_GO;
      data_reg     <= K28_5;
      is_k_reg     <= 1'b1;
      even_reg     <= 1'b1;
      ind_reg      <= 1'b0;
      align_reg    <= 1'b0;
      c_toggle_reg <= 1'b0;
      cfg_reg      <= '0;
    end else if (restart) begin
      state_reg    <= SPECIAL_GO;
      data_reg     <= K28_5;
      is_k_reg     <= 1'b1;
      even_reg     <= 1'b1;
      ind_reg      <= 1'b0;
      align_reg    <= 1'b0;
      c_toggle_reg <= 1'b0;
      cfg_reg      <= cfg_reg;
    end else begin
      state_reg    <= state_next;
      data_reg     <= data_next;
      is_k_reg     <= is_k_next;
      even_reg     <= even_next;
      ind_reg      <= ind_next;
      align_reg    <= align_next;
      c_toggle_reg <= c_toggle_next;
      cfg_reg      <= cfg_next;
    end
  end

  // SPECIAL_GO with indicate low only occurs straight after reset/restart.
  assign sample = ind_reg || (state_reg == SPECIAL_GO);

  always_comb begin
    state_next    = state_reg;
    data_next     = data_reg;
    is_k_next     = 1'b0;
    even_next     = ~even_reg;
    ind_next      = 1'b0;
    align_next    = 1'b0;
    c_toggle_next = c_toggle_reg;
    cfg_next      = cfg_reg;

    if (state_reg == CFG_K)
      cfg_next = tx_config_reg;
    if (state_reg == CFG_HI)
      c_toggle_next = ~c_toggle_reg;

    if (sample) begin
      case (tx_o_set)
        OS_S: begin
          state_next = SPECIAL_GO; data_next = K27_7; is_k_next = 1'b1; ind_next = 1'b1;
        end
        OS_T: begin
          state_next = SPECIAL_GO; data_next = K29_7; is_k_next = 1'b1; ind_next = 1'b1;
        end
        OS_R: begin
          state_next = SPECIAL_GO; data_next = K23_7; is_k_next = 1'b1; ind_next = 1'b1;
        end
        OS_V: begin
          state_next = SPECIAL_GO; data_next = K30_7; is_k_next = 1'b1; ind_next = 1'b1;
        end
        OS_D: begin
          state_next = DATA_GO; data_next = TXD; ind_next = 1'b1;
        end
        default: begin
          // K28.5-led sets: /C/, /LI/ and /I/ (also any unknown encoding).
          if (tx_o_set == OS_C)
            state_next = CFG_K;
          else if (tx_o_set == OS_LI)
            state_next = LPI_K;
          else
            state_next = IDLE_K;
          data_next  = K28_5;
          is_k_next  = 1'b1;
          even_next  = 1'b1;
          align_next = even_reg && ind_reg;
        end
      endcase
    end else begin
      case (state_reg)
        IDLE_K: begin
          state_next = IDLE_D;
          data_next  = tx_disparity_pos ? D5_6 : D16_2;
          ind_next   = 1'b1;
        end
        LPI_K: begin
          state_next = LPI_D;
          data_next  = tx_disparity_pos ? D6_5 : D26_4;
          ind_next   = 1'b1;
        end
        CFG_K: begin
          state_next = CFG_D;
          data_next  = c_toggle_reg ? D2_2 : D21_5;
        end
        CFG_D: begin
          state_next = CFG_LO;
          data_next  = cfg_reg[7:0];
        end
        CFG_LO: begin
          state_next = CFG_HI;
          data_next  = cfg_reg[15:8];
          ind_next   = 1'b1;
        end
        default: begin
          state_next = SPECIAL_GO;
          data_next  = K28_5;
          is_k_next  = 1'b1;
          even_next  = 1'b1;
        end
      endcase
    end
  end

  pcs_xmit_change_detect u_xmit_change (
    .clk              (clk),
    .rst_n            (rst_n),
    .restart          (restart),
    .xmit             (xmit),
    .tx_oset_indicate (ind_reg),
    .tx_even          (even_reg),
    .xmit_change      (xmitCHANGE)
  );

  assign tx_cg_data       = data_reg;
  assign tx_cg_is_k       = is_k_reg;
  assign tx_even          = even_reg;
  assign tx_oset_indicate = ind_reg;
  assign align_err        = align_reg;
  assign cg_state         = state_reg;

endmodule

// File: tb/tb_pcs_tx_code_group_seq.sv
// Scoreboard bench: expected code-groups are queued with stimulus and compared on the falling edge.
module tb_pcs_tx_code_group_seq;
  import pcs_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         power_on = 1'b0;
  logic         mr_main_reset = 1'b0;
  xmit_type_t   xmit = XMIT_IDLE;
  ordered_set_t tx_o_set = OS_I;
  logic [7:0]   TXD = 8'h00;
  logic [15:0]  tx_config_reg = 16'h0000;
  logic         tx_disparity_pos = 1'b0;
  logic [7:0]   tx_cg_data;
  logic         tx_cg_is_k;
  logic         tx_even;
  logic         tx_oset_indicate;
  logic         xmitCHANGE;
  logic         align_err;
  tx_cg_state_t cg_state;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0]   data;
    logic         k;
    logic         even;
    logic         ind;
    logic         xchg;
    logic         align;
    tx_cg_state_t st;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  always #5 clk = ~clk;

  pcs_tx_code_group_seq #(.CFG_W(16)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .power_on         (power_on),
    .mr_main_reset    (mr_main_reset),
    .xmit             (xmit),
    .tx_o_set         (tx_o_set),
    .TXD              (TXD),
    .tx_config_reg    (tx_config_reg),
    .tx_disparity_pos (tx_disparity_pos),
    .tx_cg_data       (tx_cg_data),
    .tx_cg_is_k       (tx_cg_is_k),
    .tx_even          (tx_even),
    .tx_oset_indicate (tx_oset_indicate),
    .xmitCHANGE       (xmitCHANGE),
    .align_err        (align_err),
    .cg_state         (cg_state)
  );

  function automatic void push(input logic [7:0] d, input logic k, input logic ev, input logic ind,
                               input logic xc, input logic al, input tx_cg_state_t st);
    exp_t x;
    x.data = d; x.k = k; x.even = ev; x.ind = ind; x.xchg = xc; x.align = al; x.st = st;
    sb.push_back(x);
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    tx_o_set = OS_I;
    tx_disparity_pos = 1'b0;
    repeat (2) @(negedge clk);
    push(8'hBC, 1, 1, 0, 0, 0, SPECIAL_GO);
    e = sb.pop_front();
    checks++;
    if ({tx_cg_data, tx_cg_is_k, tx_even, tx_oset_indicate, xmitCHANGE, align_err} !==
        {e.data, e.k, e.even, e.ind, e.xchg, e.align} || cg_state !== e.st) begin
      errors++;
      $display("FAIL reset_values got %h k%b e%b i%b x%b a%b st%0d exp %h k%b e%b i%b x%b a%b st%0d",
               tx_cg_data, tx_cg_is_k, tx_even, tx_oset_indicate, xmitCHANGE, align_err, cg_state,
               e.data, e.k, e.even, e.ind, e.xchg, e.align, e.st);
    end else $display("reset_values %h ok", tx_cg_data);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push(8'hBC, 1, 1, 0, 0, 0, IDLE_K);
      push(8'h50, 0, 0, 1, 0, 0, IDLE_D);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({tx_cg_data, tx_cg_is_k, tx_even, tx_oset_indicate, xmitCHANGE, align_err} !==
          {e.data, e.k, e.even, e.ind, e.xchg, e.align} || cg_state !== e.st) begin
        errors++;
        $display("FAIL idle[%0d] got %h k%b e%b i%b x%b a%b st%0d exp %h k%b e%b i%b x%b a%b st%0d", i,
                 tx_cg_data, tx_cg_is_k, tx_even, tx_oset_indicate, xmitCHANGE, align_err, cg_state,
                 e.data, e.k, e.even, e.ind, e.xchg, e.align, e.st);
      end else $display("idle[%0d] %h ok", i, tx_cg_data);
    end
  endtask

  task automatic test_config();
    tx_o_set = OS_C;
    tx_config_reg = 16'h01A0;
    tx_disparity_pos = 1'b1;
    push(8'hBC, 1, 1, 0, 0, 0, CFG_K);
    push(8'hB5, 0, 0, 0, 0, 0, CFG_D);
    push(8'hA0, 0, 1, 0, 0, 0, CFG_LO);
    push(8'h01, 0, 0, 1, 0, 0, CFG_HI);
    push(8'hBC, 1, 1, 0, 0, 0, CFG_K);
    push(8'h42, 0, 0, 0, 0, 0, CFG_D);
    push(8'hA0, 0, 1, 0, 0, 0, CFG_LO);
    push(8'h01, 0, 0, 1, 0, 0, CFG_HI);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({tx_cg_data, tx_cg_is_k, tx_even, tx_oset_indicate, xmitCHANGE, align_err} !==
          {e.data, e.k, e.even, e.ind, e.xchg, e.align} || cg_state !== e.st) begin
        errors++;
        $display("FAIL config[%0d] got %h k%b e%b i%b x%b a%b st%0d exp %h k%b e%b i%b x%b a%b st%0d", i,
                 tx_cg_data, tx_cg_is_k, tx_even, tx_oset_indicate, xmitCHANGE, align_err, cg_state,
                 e.data, e.k, e.even, e.ind, e.xchg, e.align, e.st);
      end else $display("config[%0d] %h ok", i, tx_cg_data);
      if (i == 1) tx_config_reg = 16'hFFFF;
      if (i == 3) tx_config_reg = 16'h01A0;
    end
  endtask

  task automatic test_stream();
    ordered_set_t os [7];
    logic [7:0]   txd_v [7];
    os = '{OS_S, OS_D, OS_D, OS_D, OS_T, OS_R, OS_R};
    txd_v = '{8'h00, 8'h55, 8'hAA, 8'h5D, 8'h00, 8'h00, 8'h00};
    push(8'hFB, 1, 1, 1, 0, 0, SPECIAL_GO);
    push(8'h55, 0, 0, 1, 0, 0, DATA_GO);
    push(8'hAA, 0, 1, 1, 0, 0, DATA_GO);
    push(8'h5D, 0, 0, 1, 0, 0, DATA_GO);
    push(8'hFD, 1, 1, 1, 0, 0, SPECIAL_GO);
    push(8'hF7, 1, 0, 1, 0, 0, SPECIAL_GO);
    push(8'hF7, 1, 1, 1, 0, 0, SPECIAL_GO);
    tx_o_set = os[0];
    TXD = txd_v[0];
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({tx_cg_data, tx_cg_is_k, tx_even, tx_oset_indicate, xmitCHANGE, align_err} !==
          {e.data, e.k, e.even, e.ind, e.xchg, e.align} || cg_state !== e.st) begin
        errors++;
        $display("FAIL stream[%0d] got %h k%b e%b i%b x%b a%b st%0d exp %h k%b e%b i%b x%b a%b st%0d", i,
                 tx_cg_data, tx_cg_is_k, tx_even, tx_oset_indicate, xmitCHANGE, align_err, cg_state,
                 e.data, e.k, e.even, e.ind, e.xchg, e.align, e.st);
      end else $display("stream[%0d] %h ok", i, tx_cg_data);
      if (i < 6) begin
        tx_o_set = os[i+1];
        TXD = txd_v[i+1];
      end
    end
  endtask

  task automatic test_odd_lpi();
    tx_disparity_pos = 1'b0;
    push(8'hF7, 1, 0, 1, 0, 0, SPECIAL_GO);
    push(8'hFD, 1, 1, 1, 0, 0, SPECIAL_GO);
    push(8'hBC, 1, 1, 0, 0, 1, LPI_K);
    push(8'h9A, 0, 0, 1, 0, 0, LPI_D);
    push(8'hBC, 1, 1, 0, 0, 0, LPI_K);
    push(8'hA6, 0, 0, 1, 0, 0, LPI_D);
    tx_o_set = OS_R;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({tx_cg_data, tx_cg_is_k, tx_even, tx_oset_indicate, xmitCHANGE, align_err} !==
          {e.data, e.k, e.even, e.ind, e.xchg, e.align} || cg_state !== e.st) begin
        errors++;
        $display("FAIL odd_lpi[%0d] got %h k%b e%b i%b x%b a%b st%0d exp %h k%b e%b i%b x%b a%b st%0d", i,
                 tx_cg_data, tx_cg_is_k, tx_even, tx_oset_indicate, xmitCHANGE, align_err, cg_state,
                 e.data, e.k, e.even, e.ind, e.xchg, e.align, e.st);
      end else $display("odd_lpi[%0d] %h align %b ok", i, tx_cg_data, align_err);
      if (i == 0) tx_o_set = OS_T;
      if (i == 1) tx_o_set = OS_LI;
      if (i == 3) tx_disparity_pos = 1'b1;
    end
  endtask

  task automatic test_xmit_change();
    tx_o_set = OS_I;
    tx_disparity_pos = 1'b0;
    xmit = XMIT_CONFIGURATION;
    for (int i = 0; i < 4; i++) begin
      push(8'hBC, 1, 1, 0, (i != 1 && i != 3), 0, IDLE_K);
      push(8'h50, 0, 0, 1, (i < 3), 0, IDLE_D);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({tx_cg_data, tx_cg_is_k, tx_even, tx_oset_indicate, xmitCHANGE, align_err} !==
          {e.data, e.k, e.even, e.ind, e.xchg, e.align} || cg_state !== e.st) begin
        errors++;
        $display("FAIL xmit[%0d] got %h k%b e%b i%b x%b a%b st%0d exp %h k%b e%b i%b x%b a%b st%0d", i,
                 tx_cg_data, tx_cg_is_k, tx_even, tx_oset_indicate, xmitCHANGE, align_err, cg_state,
                 e.data, e.k, e.even, e.ind, e.xchg, e.align, e.st);
      end else $display("xmit[%0d] xmitCHANGE %b ok", i, xmitCHANGE);
      if (i == 2) xmit = XMIT_DATA;
      if (i == 3) xmit = XMIT_IDLE;
    end
  endtask

  task automatic test_restart();
    tx_o_set = OS_C;
    tx_config_reg = 16'h01A0;
    tx_disparity_pos = 1'b1;
    push(8'hBC, 1, 1, 0, 0, 0, CFG_K);
    push(8'hB5, 0, 0, 0, 0, 0, CFG_D);
    push(8'hA0, 0, 1, 0, 0, 0, CFG_LO);
    push(8'h01, 0, 0, 1, 0, 0, CFG_HI);
    push(8'hBC, 1, 1, 0, 0, 0, CFG_K);
    push(8'h42, 0, 0, 0, 0, 0, CFG_D);
    push(8'hA0, 0, 1, 0, 0, 0, CFG_LO);
    push(8'hBC, 1, 1, 0, 0, 0, SPECIAL_GO);
    push(8'hBC, 1, 1, 0, 0, 0, CFG_K);
    push(8'hB5, 0, 0, 0, 0, 0, CFG_D);
    push(8'hA0, 0, 1, 0, 0, 0, CFG_LO);
    push(8'h01, 0, 0, 1, 0, 0, CFG_HI);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({tx_cg_data, tx_cg_is_k, tx_even, tx_oset_indicate, xmitCHANGE, align_err} !==
          {e.data, e.k, e.even, e.ind, e.xchg, e.align} || cg_state !== e.st) begin
        errors++;
        $display("FAIL restart[%0d] got %h k%b e%b i%b x%b a%b st%0d exp %h k%b e%b i%b x%b a%b st%0d", i,
                 tx_cg_data, tx_cg_is_k, tx_even, tx_oset_indicate, xmitCHANGE, align_err, cg_state,
                 e.data, e.k, e.even, e.ind, e.xchg, e.align, e.st);
      end else $display("restart[%0d] %h ok", i, tx_cg_data);
      mr_main_reset = (i == 6);
    end
  endtask

  task automatic test_power_on_unknown();
    tx_o_set = OS_I;
    power_on = 1'b1;
    push(8'hBC, 1, 1, 0, 0, 0, SPECIAL_GO);
    push(8'hBC, 1, 1, 0, 0, 0, IDLE_K);
    push(8'hC5, 0, 0, 1, 0, 0, IDLE_D);
    push(8'hBC, 1, 1, 0, 0, 0, IDLE_K);
    push(8'hC5, 0, 0, 1, 0, 0, IDLE_D);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({tx_cg_data, tx_cg_is_k, tx_even, tx_oset_indicate, xmitCHANGE, align_err} !==
          {e.data, e.k, e.even, e.ind, e.xchg, e.align} || cg_state !== e.st) begin
        errors++;
        $display("FAIL power_unknown[%0d] got %h k%b e%b i%b x%b a%b st%0d exp %h k%b e%b i%b x%b a%b st%0d", i,
                 tx_cg_data, tx_cg_is_k, tx_even, tx_oset_indicate, xmitCHANGE, align_err, cg_state,
                 e.data, e.k, e.even, e.ind, e.xchg, e.align, e.st);
      end else $display("power_unknown[%0d] %h ok", i, tx_cg_data);
      power_on = 1'b0;
      if (i == 2) tx_o_set = ordered_set_t'(4'hF);
    end
  endtask

  initial begin
    test_reset();
    test_config();
    test_stream();
    test_odd_lpi();
    test_xmit_change();
    test_restart();
    test_power_on_unknown();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
